// File: rtl/div_pkg.sv
// Shared encodings and default width for the button-calculator divider slice.
package div_pkg;

  localparam int W = 4;

  typedef enum logic [2:0] {
    LOAD_NUM  = 3'd0,
    LOAD_DEN  = 3'd1,
    DIVIDE    = 3'd2,
    SHOW_QUOT = 3'd3,
    SHOW_REM  = 3'd4,
    ERR       = 3'd5
  } state_t;

endpackage

// File: rtl/div_seq_core.sv
// Iterative restoring divider: one quotient bit per cycle, W iterations after start.
module div_seq_core
  import div_pkg::*;
#(
  parameter int W = div_pkg::W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic [W:0]    r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_den;
  logic [CW-1:0] r_cnt;
  logic          r_busy;

  logic [W:0]    w_rem_sh;
  logic          w_fits;

  // {r,q} shifted left by one; the trial subtraction succeeds when it stays non-negative.
  assign w_rem_sh = {r_rem[W-1:0], r_quo[W-1]};
  assign w_fits   = (w_rem_sh >= {1'b0, r_den});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_den  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (r_busy) begin
      r_rem <= w_fits ? (w_rem_sh - {1'b0, r_den}) : w_rem_sh;
      r_quo <= {r_quo[W-2:0], w_fits};
      if (r_cnt == CW'(W - 1)) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (start) begin
      r_rem  <= '0;
      r_quo  <= dividend;
      r_den  <= divisor;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end
  end

  // Done marks the final iteration cycle; results settle at the end of it.
  assign done      = r_busy && (r_cnt == CW'(W - 1));
  assign busy      = r_busy;
  assign quotient  = r_quo;
  assign remainder = r_rem[W-1:0];

endmodule

// File: rtl/div_seq_ctrl.sv
// Calculator controller: operand editing FSM, divider sequencing and LED word mux.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int W = div_pkg::W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         next_tick,
  input  logic         up_tick,
  input  logic         down_tick,
  output logic [W-1:0] leds,
  output logic [2:0]   state_o,
  output logic         busy,
  output logic         err
);

  state_t       r_state;
  logic [W-1:0] r_num;
  logic [W-1:0] r_den;
  logic         r_start;

  logic         w_up;
  logic         w_dn;
  logic [W-1:0] w_quo;
  logic [W-1:0] w_rem;
  logic         w_core_busy;
  logic         w_done;

  // Simultaneous up and down cancel out.
  assign w_up = up_tick & ~down_tick;
  assign w_dn = down_tick & ~up_tick;

  div_seq_core #(.W(W)) u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (r_start),
    .dividend  (r_num),
    .divisor   (r_den),
    .quotient  (w_quo),
    .remainder (w_rem),
    .busy      (w_core_busy),
    .done      (w_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= LOAD_NUM;
      r_num   <= '0;
      r_den   <= '0;
      r_start <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        LOAD_NUM: begin
          if (w_up)      r_num <= r_num + 1'b1;
          else if (w_dn) r_num <= r_num - 1'b1;
          if (next_tick) r_state <= LOAD_DEN;
        end
        LOAD_DEN: begin
          if (w_up)      r_den <= r_den + 1'b1;
          else if (w_dn) r_den <= r_den - 1'b1;
          if (next_tick) begin
            if (r_den != '0) begin
              r_state <= DIVIDE;
              r_start <= 1'b1;
            end else begin
              r_state <= ERR;
            end
          end
        end
        DIVIDE:    if (w_done)    r_state <= SHOW_QUOT;
        SHOW_QUOT: if (next_tick) r_state <= SHOW_REM;
        SHOW_REM:  if (next_tick) r_state <= LOAD_NUM;
        ERR:       if (next_tick) r_state <= LOAD_NUM;
        default:                  r_state <= LOAD_NUM;
      endcase
    end
  end

  always_comb begin
    leds = '0;
    case (r_state)
      LOAD_NUM:  leds = r_num;
      LOAD_DEN:  leds = r_den;
      SHOW_QUOT: leds = w_quo;
      SHOW_REM:  leds = w_rem;
      ERR:       leds = '1;
      default:   leds = '0;
    endcase
  end

  assign state_o = r_state;
  assign busy    = w_core_busy;
  assign err     = (r_state == ERR);

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench: randomized button sequences against an arithmetic model of the calculator.
module tb_div_seq_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         next_tick = 1'b0;
  logic         up_tick = 1'b0;
  logic         down_tick = 1'b0;
  logic [W-1:0] leds;
  logic [2:0]   state_o;
  logic         busy;
  logic         err;

  always #5 clk = ~clk;

  div_seq_ctrl #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .next_tick (next_tick),
    .up_tick   (up_tick),
    .down_tick (down_tick),
    .leds      (leds),
    .state_o   (state_o),
    .busy      (busy),
    .err       (err)
  );

  int checks = 0;
  int errors = 0;

  // Model: state number, operands, last results, and cycle index within DIVIDE (1-based).
  int ms, mnum, mden, mq, mr, dcyc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_leds();
    case (ms)
      0: return mnum;
      1: return mden;
      3: return mq;
      4: return mr;
      5: return 15;
      default: return 0;
    endcase
  endfunction

  task automatic compare_all();
    chk("leds", int'(leds), exp_leds());
    chk("state", int'(state_o), ms);
    chk("busy", int'(busy), (ms == 2 && dcyc >= 2) ? 1 : 0);
    chk("err", int'(err), (ms == 5) ? 1 : 0);
  endtask

  task automatic model_reset();
    ms = 0; mnum = 0; mden = 0; mq = 0; mr = 0; dcyc = 0;
  endtask

  task automatic model_step(input bit n, input bit u, input bit d);
    int delta;
    int old_den;
    delta = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
    case (ms)
      0: begin
        mnum = (mnum + delta + 16) % 16;
        if (n) ms = 1;
      end
      1: begin
        old_den = mden;
        mden = (mden + delta + 16) % 16;
        if (n) begin
          if (old_den != 0) begin ms = 2; dcyc = 1; end
          else ms = 5;
        end
      end
      2: begin
        if (dcyc == W + 1) begin
          ms = 3; mq = mnum / mden; mr = mnum % mden;
        end else begin
          dcyc++;
        end
      end
      3: if (n) ms = 4;
      4: if (n) ms = 0;
      5: if (n) ms = 0;
      default: ms = 0;
    endcase
  endtask

  // One clock: drive ticks, advance the model at the edge, compare at the falling edge.
  task automatic step(input bit n, input bit u, input bit d);
    next_tick = n; up_tick = u; down_tick = d;
    @(posedge clk);
    model_step(n, u, d);
    @(negedge clk);
    next_tick = 1'b0; up_tick = 1'b0; down_tick = 1'b0;
    compare_all();
  endtask

  task automatic edit_to(input int target);
    int cur, diff;
    for (int k = 0; k < 40; k++) begin
      cur = (ms == 0) ? mnum : mden;
      if (cur == target) break;
      diff = (target - cur + 16) % 16;
      if ($urandom_range(0, 7) == 0) step(1'b0, 1'b1, 1'b1);
      else if (diff <= 8)            step(1'b0, 1'b1, 1'b0);
      else                           step(1'b0, 1'b0, 1'b1);
    end
  endtask

  // Loads a, b and divides, leaving the design in SHOW_QUOT; lat counts cycles from next to SHOW_QUOT.
  task automatic run_div(input int a, input int b, output int lat);
    edit_to(a);
    step(1'b1, 1'b0, 1'b0);
    edit_to(b);
    step(1'b1, 1'b0, 1'b0);
    lat = 1;
    while (state_o != 3'd3 && lat < 20) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      lat++;
    end
    chk("latency", lat, W + 2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busy_cnt;
    model_reset();
    @(negedge clk);
    compare_all();
    chk("reset_leds", int'(leds), 0);
    @(negedge clk);
    reset = 1'b0;

    // 13 / 3 walk-through with literal expectations.
    repeat (13) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    busy_cnt = int'(busy);
    for (int k = 0; k < 12 && state_o != 3'd3; k++) begin
      step(1'b0, 1'b0, 1'b0);
      busy_cnt += int'(busy);
    end
    chk("busy_cycles", busy_cnt, 4);
    chk("q_13_3", int'(leds), 4);
    step(1'b1, 1'b0, 1'b0);
    chk("r_13_3", int'(leds), 1);
    step(1'b1, 1'b0, 1'b0);
    chk("back_state", int'(state_o), 0);
    chk("back_num", int'(leds), 13);

    // 15 / 1 and 7 / 9.
    run_div(15, 1, lat);
    chk("q_15_1", int'(leds), 15);
    step(1'b1, 1'b0, 1'b0);
    chk("r_15_1", int'(leds), 0);
    step(1'b1, 1'b0, 1'b0);
    run_div(7, 9, lat);
    chk("q_7_9", int'(leds), 0);
    step(1'b1, 1'b0, 1'b0);
    chk("r_7_9", int'(leds), 7);
    step(1'b1, 1'b0, 1'b0);

    // Division by zero.
    step(1'b1, 1'b0, 1'b0);
    edit_to(0);
    step(1'b1, 1'b0, 1'b0);
    chk("err_flag", int'(err), 1);
    chk("err_leds", int'(leds), 15);
    chk("err_state", int'(state_o), 5);
    step(1'b1, 1'b0, 1'b0);
    chk("err_exit_state", int'(state_o), 0);
    chk("err_exit_flag", int'(err), 0);

    // Wrap and cancelling ticks.
    edit_to(0);
    repeat (16) step(1'b0, 1'b1, 1'b0);
    chk("wrap16", int'(leds), 0);
    step(1'b0, 1'b1, 1'b1);
    chk("updown", int'(leds), 0);
    step(1'b0, 1'b0, 1'b1);
    chk("down_wrap", int'(leds), 15);

    // Reset two cycles into DIVIDE.
    edit_to(13);
    step(1'b1, 1'b0, 1'b0);
    edit_to(3);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    compare_all();
    chk("rst_state", int'(state_o), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    chk("rst_den", int'(leds), 0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Exhaustive sweep; the model checks quotient/remainder on every cycle.
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_div(a, b, lat);
        step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        step(1'b1, 1'b0, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
